vga_ball_gen: RTL and testbench

VGA_BALL_GEN -- requirements
Module: vga_ball_gen

---
 rtl/vga_game_pkg.sv | 38 +++
 rtl/rect_hit.sv | 24 ++
 rtl/vga_ball_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_ball_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vga_game_pkg.sv
// Shared screen geometry, colours, FSM state encoding and a clamp helper
// for the bouncing-ball game.
package vga_game_pkg;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;
    localparam int PADDLE_H = 12;
    localparam int SCORE_H  = 8;

    localparam logic [23:0] COL_BALL   = 24'hFFFFFF;
    localparam logic [23:0] COL_PADDLE = 24'h00FF00;
    localparam logic [23:0] COL_SCORE  = 24'hFFD700;
    localparam logic [23:0] COL_BG     = 24'h000040;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } state_e;

    // Saturate a signed position into [lo, hi].
    function automatic logic signed [10:0] clamp11(
        input logic signed [10:0] v,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        logic signed [10:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle test: hit when x0 <= x < x0+w and
// y0 <= y < y0+h. Widened sums avoid overflow at the screen edge.
module rect_hit #(
    parameter int W = 11
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] x0_i,
    input  logic [W-1:0] y0_i,
    input  logic [W-1:0] w_i,
    input  logic [W-1:0] h_i,
    output logic         hit_o
);

    logic [W:0] x_end_s;
    logic [W:0] y_end_s;

    assign x_end_s = {1'b0, x0_i} + {1'b0, w_i};
    assign y_end_s = {1'b0, y0_i} + {1'b0, h_i};

    assign hit_o = (x_i >= x0_i) && ({1'b0, x_i} < x_end_s) &&
                   (y_i >= y0_i) && ({1'b0, y_i} < y_end_s);

endmodule

// File: rtl/vga_ball_gen.sv
// Bouncing ball + paddle game renderer, updated once per frame on the vsync
// falling edge. Define VGA_BALL_SCORE_EN to build the score counter and bar.
module vga_ball_gen
    import vga_game_pkg::*;
#(
    parameter int BALL_SIZE   = 16,
    parameter int PADDLE_W    = 96,
    parameter int PADDLE_Y    = 560,
    parameter int SPEED       = 4,
    parameter int MISS_FRAMES = 60
) (
    input  logic        clk_40mhz,
    input  logic        rst,
    input  logic [9:0]  vga_xide,
    input  logic [9:0]  vga_yide,
    input  logic        vga_vs,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [23:0] vga_data
);

    localparam logic signed [10:0] SPD       = 11'(SPEED);
    localparam logic signed [10:0] BSZ       = 11'(BALL_SIZE);
    localparam logic signed [10:0] PW        = 11'(PADDLE_W);
    localparam logic signed [10:0] PY        = 11'(PADDLE_Y);
    localparam logic signed [10:0] X_MAX     = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] P_MAX     = 11'(SCREEN_W - PADDLE_W);
    localparam logic signed [10:0] Y_BOT     = 11'(SCREEN_H);
    localparam logic signed [10:0] SERVE_X   = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic signed [10:0] SERVE_Y   = 11'sd100;
    localparam logic signed [10:0] PADDLE_X0 = 11'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [7:0]         MISS_LOAD = 8'(MISS_FRAMES - 1);

    state_e             state_q,    state_d;
    logic signed [10:0] ball_x_q,   ball_x_d;
    logic signed [10:0] ball_y_q,   ball_y_d;
    logic signed [10:0] vx_q,       vx_d;
    logic signed [10:0] vy_q,       vy_d;
    logic signed [10:0] paddle_x_q, paddle_x_d;
    logic [7:0]         miss_cnt_q, miss_cnt_d;
    logic               vs_q;
    logic [23:0]        vga_data_q, vga_data_d;

    logic               frame_tick_s;
    logic signed [10:0] nx_s;
    logic signed [10:0] ny_s;
    logic signed [10:0] pn_s;
    logic               hit_s;
    logic [10:0]        px_s;
    logic [10:0]        py_s;
    logic               ball_pix_s;
    logic               paddle_pix_s;
    logic               score_pix_s;

`ifdef VGA_BALL_SCORE_EN
    logic [5:0]         score_q, score_d;
`endif

    assign frame_tick_s = vs_q & ~vga_vs;
    assign px_s         = {1'b0, vga_xide};
    assign py_s         = {1'b0, vga_yide};
    assign vga_data     = vga_data_q;

    // Candidate positions and paddle contact, all in 11-bit signed space.
    always_comb begin
        nx_s  = ball_x_q + vx_q;
        ny_s  = ball_y_q + vy_q;
        hit_s = (vy_q > 11'sd0) && ((ny_s + BSZ) >= PY) &&
                (ball_x_q < (paddle_x_q + PW)) && ((ball_x_q + BSZ) > paddle_x_q);
        if (btn_left && !btn_right) begin
            pn_s = clamp11(paddle_x_q - SPD, 11'sd0, P_MAX);
        end else if (btn_right && !btn_left) begin
            pn_s = clamp11(paddle_x_q + SPD, 11'sd0, P_MAX);
        end else begin
            pn_s = paddle_x_q;
        end
    end

    // Per-frame game state: FSM, ball physics, paddle, miss timer, score.
    always_comb begin
        state_d    = state_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        paddle_x_d = paddle_x_q;
        miss_cnt_d = miss_cnt_q;
`ifdef VGA_BALL_SCORE_EN
        score_d    = score_q;
`endif
        if (frame_tick_s) begin
            paddle_x_d = pn_s;
            case (state_q)
                ST_SERVE: begin
                    state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (!hit_s && ((ny_s + BSZ) >= Y_BOT)) begin
                        state_d    = ST_MISS;
                        miss_cnt_d = MISS_LOAD;
                    end else begin
                        // X and Y resolve independently so a corner hits both.
                        if (nx_s <= 11'sd0) begin
                            ball_x_d = 11'sd0;
                            vx_d     = SPD;
                        end else if (nx_s >= X_MAX) begin
                            ball_x_d = X_MAX;
                            vx_d     = -SPD;
                        end else begin
                            ball_x_d = nx_s;
                        end
                        if (ny_s <= 11'sd0) begin
                            ball_y_d = 11'sd0;
                            vy_d     = SPD;
                        end else if (hit_s) begin
                            ball_y_d = PY - BSZ;
                            vy_d     = -SPD;
                        end else begin
                            ball_y_d = ny_s;
                        end
`ifdef VGA_BALL_SCORE_EN
                        if (hit_s && (score_q != 6'd63)) begin
                            score_d = score_q + 6'd1;
                        end else begin
                            score_d = score_q;
                        end
`endif
                    end
                end
                ST_MISS: begin
                    if (miss_cnt_q == 8'd0) begin
                        state_d  = ST_SERVE;
                        ball_x_d = SERVE_X;
                        ball_y_d = SERVE_Y;
                        vx_d     = SPD;
                        vy_d     = SPD;
`ifdef VGA_BALL_SCORE_EN
                        score_d  = 6'd0;
`endif
                    end else begin
                        miss_cnt_d = miss_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_SERVE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    rect_hit #(.W(11)) u_ball_hit (
        .x_i   (px_s),
        .y_i   (py_s),
        .x0_i  ($unsigned(ball_x_q)),
        .y0_i  ($unsigned(ball_y_q)),
        .w_i   ($unsigned(BSZ)),
        .h_i   ($unsigned(BSZ)),
        .hit_o (ball_pix_s)
    );

    rect_hit #(.W(11)) u_paddle_hit (
        .x_i   (px_s),
        .y_i   (py_s),
        .x0_i  ($unsigned(paddle_x_q)),
        .y0_i  ($unsigned(PY)),
        .w_i   ($unsigned(PW)),
        .h_i   (11'(PADDLE_H)),
        .hit_o (paddle_pix_s)
    );

`ifdef VGA_BALL_SCORE_EN
    rect_hit #(.W(11)) u_score_hit (
        .x_i   (px_s),
        .y_i   (py_s),
        .x0_i  (11'd0),
        .y0_i  (11'd0),
        .w_i   ({2'b00, score_q, 3'b000}),
        .h_i   (11'(SCORE_H)),
        .hit_o (score_pix_s)
    );
`else
    assign score_pix_s = 1'b0;
`endif

    // Pixel colour by layer priority; registered one cycle behind the scan.
    always_comb begin
        if (ball_pix_s) begin
            vga_data_d = COL_BALL;
        end else if (paddle_pix_s) begin
            vga_data_d = COL_PADDLE;
        end else if (score_pix_s) begin
            vga_data_d = COL_SCORE;
        end else begin
            vga_data_d = COL_BG;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_40mhz) begin
        if (rst) begin
            state_q    <= ST_SERVE;
            ball_x_q   <= SERVE_X;
            ball_y_q   <= SERVE_Y;
            vx_q       <= SPD;
            vy_q       <= SPD;
            paddle_x_q <= PADDLE_X0;
            miss_cnt_q <= 8'd0;
            vs_q       <= 1'b1;
            vga_data_q <= 24'h000000;
`ifdef VGA_BALL_SCORE_EN
            score_q    <= 6'd0;
`endif
        end else begin
            state_q    <= state_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            paddle_x_q <= paddle_x_d;
            miss_cnt_q <= miss_cnt_d;
            vs_q       <= vga_vs;
            vga_data_q <= vga_data_d;
`ifdef VGA_BALL_SCORE_EN
            score_q    <= score_d;
`endif
        end
    end

endmodule

// File: tb/tb_vga_ball_gen.sv
// Directed bench for vga_ball_gen: short synthetic frames, expected game
// state hand-computed from the ball trajectory starting at the serve point.
module tb_vga_ball_gen;
    import vga_game_pkg::*;

    logic        clk_40mhz;
    logic        rst;
    logic [9:0]  vga_xide;
    logic [9:0]  vga_yide;
    logic        vga_vs;
    logic        btn_left;
    logic        btn_right;
    logic [23:0] vga_data;

    int tests;
    int fails;

    vga_ball_gen dut (
        .clk_40mhz (clk_40mhz),
        .rst       (rst),
        .vga_xide  (vga_xide),
        .vga_yide  (vga_yide),
        .vga_vs    (vga_vs),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .vga_data  (vga_data)
    );

    initial clk_40mhz = 1'b0;
    always #5 clk_40mhz = ~clk_40mhz;

    // Hold reset for two cycles, inputs idle; leaves rst asserted.
    task automatic assert_reset();
        @(negedge clk_40mhz);
        rst = 1'b1; vga_vs = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
        vga_xide = 10'd0; vga_yide = 10'd0;
        repeat (2) @(negedge clk_40mhz);
    endtask

    task automatic do_reset();
        assert_reset();
        rst = 1'b0;
        @(negedge clk_40mhz);
    endtask

    // Each frame: vsync low two cycles, high two cycles -> one frame_tick.
    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            vga_vs = 1'b0;
            repeat (2) @(negedge clk_40mhz);
            vga_vs = 1'b1;
            repeat (2) @(negedge clk_40mhz);
        end
    endtask

    task automatic test_reset();
        assert_reset();
        tests++; if (dut.state_q !== ST_SERVE) begin fails++; $display("FAIL rst_state got %0d exp %0d", dut.state_q, ST_SERVE); end
        tests++; if (int'(dut.ball_x_q) !== 392) begin fails++; $display("FAIL rst_ball_x got %0d exp 392", int'(dut.ball_x_q)); end
        tests++; if (int'(dut.ball_y_q) !== 100) begin fails++; $display("FAIL rst_ball_y got %0d exp 100", int'(dut.ball_y_q)); end
        tests++; if (int'(dut.vx_q) !== 4 || int'(dut.vy_q) !== 4) begin fails++; $display("FAIL rst_vel got %0d,%0d exp 4,4", int'(dut.vx_q), int'(dut.vy_q)); end
        tests++; if (int'(dut.paddle_x_q) !== 352) begin fails++; $display("FAIL rst_paddle got %0d exp 352", int'(dut.paddle_x_q)); end
        tests++; if (dut.miss_cnt_q !== 8'd0) begin fails++; $display("FAIL rst_miss_cnt got %0d exp 0", dut.miss_cnt_q); end
        tests++; if (vga_data !== 24'h000000) begin fails++; $display("FAIL rst_vga_data got %h exp 000000", vga_data); end
        tests++; if (dut.vs_q !== 1'b1) begin fails++; $display("FAIL rst_vs_d got %b exp 1", dut.vs_q); end
`ifdef VGA_BALL_SCORE_EN
        tests++; if (dut.score_q !== 6'd0) begin fails++; $display("FAIL rst_score got %0d exp 0", dut.score_q); end
`endif
        rst = 1'b0;
        @(negedge clk_40mhz);
    endtask

    task automatic test_pixels();
        do_reset();
        vga_xide = 10'd395; vga_yide = 10'd103;
        @(negedge clk_40mhz);
        tests++; if (vga_data !== 24'hFFFFFF) begin fails++; $display("FAIL pix_ball got %h exp FFFFFF", vga_data); end
        vga_xide = 10'd0; vga_yide = 10'd300;
        @(negedge clk_40mhz);
        tests++; if (vga_data !== 24'h000040) begin fails++; $display("FAIL pix_bg got %h exp 000040", vga_data); end
        vga_xide = 10'd360; vga_yide = 10'd565;
        @(negedge clk_40mhz);
        tests++; if (vga_data !== 24'h00FF00) begin fails++; $display("FAIL pix_paddle got %h exp 00FF00", vga_data); end
        vga_xide = 10'd408; vga_yide = 10'd100;
        @(negedge clk_40mhz);
        tests++; if (vga_data !== 24'h000040) begin fails++; $display("FAIL pix_ball_edge got %h exp 000040", vga_data); end
        vga_xide = 10'd0; vga_yide = 10'd0;
        @(negedge clk_40mhz);
        tests++; if (vga_data !== 24'h000040) begin fails++; $display("FAIL pix_score_empty got %h exp 000040", vga_data); end
    endtask

    task automatic test_serve_play();
        do_reset();
        frame_ticks(1);
        tests++; if (dut.state_q !== ST_PLAY || int'(dut.ball_x_q) !== 392 || int'(dut.ball_y_q) !== 100) begin fails++; $display("FAIL serve_to_play got st=%0d (%0d,%0d) exp st=1 (392,100)", dut.state_q, int'(dut.ball_x_q), int'(dut.ball_y_q)); end
        frame_ticks(1);
        tests++; if (dut.state_q !== ST_PLAY || int'(dut.ball_x_q) !== 396 || int'(dut.ball_y_q) !== 104) begin fails++; $display("FAIL first_step got st=%0d (%0d,%0d) exp st=1 (396,104)", dut.state_q, int'(dut.ball_x_q), int'(dut.ball_y_q)); end
    endtask

    task automatic test_paddle_walls();
        do_reset();
        btn_right = 1'b1;
        frame_ticks(98);
        tests++; if (int'(dut.ball_x_q) !== 780 || int'(dut.vx_q) !== 4) begin fails++; $display("FAIL pre_right_wall got x=%0d vx=%0d exp x=780 vx=4", int'(dut.ball_x_q), int'(dut.vx_q)); end
        frame_ticks(1);
        tests++; if (int'(dut.ball_x_q) !== 784 || int'(dut.vx_q) !== -4) begin fails++; $display("FAIL right_wall got x=%0d vx=%0d exp x=784 vx=-4", int'(dut.ball_x_q), int'(dut.vx_q)); end
        frame_ticks(1);
        tests++; if (int'(dut.paddle_x_q) !== 704) begin fails++; $display("FAIL paddle_sat_right got %0d exp 704", int'(dut.paddle_x_q)); end
        btn_left = 1'b1;
        frame_ticks(5);
        tests++; if (int'(dut.paddle_x_q) !== 704) begin fails++; $display("FAIL paddle_both_btn got %0d exp 704", int'(dut.paddle_x_q)); end
        frame_ticks(6);
        tests++; if (int'(dut.ball_x_q) !== 736 || int'(dut.ball_y_q) !== 540 || int'(dut.vy_q) !== 4) begin fails++; $display("FAIL pre_paddle got (%0d,%0d) vy=%0d exp (736,540) vy=4", int'(dut.ball_x_q), int'(dut.ball_y_q), int'(dut.vy_q)); end
        frame_ticks(1);
        tests++; if (int'(dut.ball_x_q) !== 732 || int'(dut.ball_y_q) !== 544 || int'(dut.vy_q) !== -4) begin fails++; $display("FAIL paddle_hit got (%0d,%0d) vy=%0d exp (732,544) vy=-4", int'(dut.ball_x_q), int'(dut.ball_y_q), int'(dut.vy_q)); end
        tests++; if (dut.state_q !== ST_PLAY) begin fails++; $display("FAIL paddle_hit_state got %0d exp 1", dut.state_q); end
`ifdef VGA_BALL_SCORE_EN
        tests++; if (dut.score_q !== 6'd1) begin fails++; $display("FAIL score_inc got %0d exp 1", dut.score_q); end
`endif
        btn_left = 1'b0; btn_right = 1'b0;
        frame_ticks(135);
        tests++; if (int'(dut.ball_x_q) !== 192 || int'(dut.ball_y_q) !== 4 || int'(dut.vy_q) !== -4) begin fails++; $display("FAIL pre_top got (%0d,%0d) vy=%0d exp (192,4) vy=-4", int'(dut.ball_x_q), int'(dut.ball_y_q), int'(dut.vy_q)); end
        frame_ticks(1);
        tests++; if (int'(dut.ball_x_q) !== 188 || int'(dut.ball_y_q) !== 0 || int'(dut.vy_q) !== 4) begin fails++; $display("FAIL top_wall got (%0d,%0d) vy=%0d exp (188,0) vy=4", int'(dut.ball_x_q), int'(dut.ball_y_q), int'(dut.vy_q)); end
        frame_ticks(46);
        tests++; if (int'(dut.ball_x_q) !== 4 || int'(dut.vx_q) !== -4 || int'(dut.ball_y_q) !== 184) begin fails++; $display("FAIL pre_left got x=%0d vx=%0d y=%0d exp x=4 vx=-4 y=184", int'(dut.ball_x_q), int'(dut.vx_q), int'(dut.ball_y_q)); end
        frame_ticks(1);
        tests++; if (int'(dut.ball_x_q) !== 0 || int'(dut.vx_q) !== 4 || int'(dut.ball_y_q) !== 188) begin fails++; $display("FAIL left_wall got x=%0d vx=%0d y=%0d exp x=0 vx=4 y=188", int'(dut.ball_x_q), int'(dut.vx_q), int'(dut.ball_y_q)); end
        tests++; if (int'(dut.paddle_x_q) !== 704) begin fails++; $display("FAIL paddle_idle got %0d exp 704", int'(dut.paddle_x_q)); end
    endtask

    task automatic test_miss();
        do_reset();
        btn_left = 1'b1;
        frame_ticks(100);
        tests++; if (int'(dut.paddle_x_q) !== 0) begin fails++; $display("FAIL paddle_sat_left got %0d exp 0", int'(dut.paddle_x_q)); end
        frame_ticks(21);
        tests++; if (dut.state_q !== ST_PLAY || int'(dut.ball_x_q) !== 696 || int'(dut.ball_y_q) !== 580) begin fails++; $display("FAIL pre_miss got st=%0d (%0d,%0d) exp st=1 (696,580)", dut.state_q, int'(dut.ball_x_q), int'(dut.ball_y_q)); end
        frame_ticks(1);
        tests++; if (dut.state_q !== ST_MISS || dut.miss_cnt_q !== 8'd59) begin fails++; $display("FAIL miss_entry got st=%0d cnt=%0d exp st=2 cnt=59", dut.state_q, dut.miss_cnt_q); end
        tests++; if (int'(dut.ball_x_q) !== 696 || int'(dut.ball_y_q) !== 580) begin fails++; $display("FAIL miss_freeze0 got (%0d,%0d) exp (696,580)", int'(dut.ball_x_q), int'(dut.ball_y_q)); end
        frame_ticks(59);
        tests++; if (dut.state_q !== ST_MISS || dut.miss_cnt_q !== 8'd0 || int'(dut.ball_x_q) !== 696 || int'(dut.ball_y_q) !== 580) begin fails++; $display("FAIL miss_last got st=%0d cnt=%0d (%0d,%0d) exp st=2 cnt=0 (696,580)", dut.state_q, dut.miss_cnt_q, int'(dut.ball_x_q), int'(dut.ball_y_q)); end
        frame_ticks(1);
        tests++; if (dut.state_q !== ST_SERVE || int'(dut.ball_x_q) !== 392 || int'(dut.ball_y_q) !== 100) begin fails++; $display("FAIL reserve got st=%0d (%0d,%0d) exp st=0 (392,100)", dut.state_q, int'(dut.ball_x_q), int'(dut.ball_y_q)); end
        tests++; if (int'(dut.vx_q) !== 4 || int'(dut.vy_q) !== 4) begin fails++; $display("FAIL reserve_vel got %0d,%0d exp 4,4", int'(dut.vx_q), int'(dut.vy_q)); end
`ifdef VGA_BALL_SCORE_EN
        tests++; if (dut.score_q !== 6'd0) begin fails++; $display("FAIL score_clear got %0d exp 0", dut.score_q); end
`endif
        frame_ticks(1);
        tests++; if (dut.state_q !== ST_PLAY) begin fails++; $display("FAIL reserve_play got %0d exp 1", dut.state_q); end
        btn_left = 1'b0;
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        btn_left = 1'b1;
        frame_ticks(125);
        tests++; if (dut.state_q !== ST_MISS || dut.miss_cnt_q !== 8'd56) begin fails++; $display("FAIL mid_miss got st=%0d cnt=%0d exp st=2 cnt=56", dut.state_q, dut.miss_cnt_q); end
        rst = 1'b1;
        @(negedge clk_40mhz);
        tests++; if (dut.state_q !== ST_SERVE || dut.miss_cnt_q !== 8'd0 || int'(dut.paddle_x_q) !== 352) begin fails++; $display("FAIL rst_mid_miss got st=%0d cnt=%0d pad=%0d exp st=0 cnt=0 pad=352", dut.state_q, dut.miss_cnt_q, int'(dut.paddle_x_q)); end
        tests++; if (int'(dut.ball_x_q) !== 392 || int'(dut.ball_y_q) !== 100) begin fails++; $display("FAIL rst_mid_miss_ball got (%0d,%0d) exp (392,100)", int'(dut.ball_x_q), int'(dut.ball_y_q)); end
        rst = 1'b0; btn_left = 1'b0;
        @(negedge clk_40mhz);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; vga_vs = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
        vga_xide = 10'd0; vga_yide = 10'd0;
        test_reset();
        test_pixels();
        test_serve_play();
        test_paddle_walls();
        test_miss();
        test_reset_mid_miss();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
